pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  IF-stage owner of the architectural PC. Consumes the redirect target computed
//  in EX by the next-PC logic, issues word fetches to instruction memory over a
//  req/gnt + rvalid interface and buffers returned instructions for ID via valid/ready.
//  Sits between the next-PC logic/hazard unit and the IF/ID pipeline register.
// PARAMETERS
//  RESET_PC    32'h0000_0000  PC fetched first after reset
//  FIFO_DEPTH  4              instruction buffer entries (power of 2, >=2); also max outstanding fetches
// PORTS
//  clk             in   1   clock, all state on rising edge
//  rst_n           in   1   asynchronous active-low reset
//  redirect_valid  in   1   EX resolved taken branch/jal/jalr this cycle
//  redirect_pc     in   32  new fetch target; bits [1:0] forced to 0
//  imem_req        out  1   fetch request valid
//  imem_addr       out  32  fetch word address (pc_q)
//  imem_gnt        in   1   request accepted this cycle
//  imem_rvalid     in   1   response valid (in request order, >=1 cycle after grant)
//  imem_rdata      in   32  response instruction word
//  if_valid        out  1   buffered instruction available to ID
//  if_ready        in   1   ID accepts (low = stall from hazard unit)
//  if_pc           out  32  PC of presented instruction
//  if_pc4          out  32  if_pc + 4 (link value for jal/jalr)
//  if_inst         out  32  presented instruction word
// BEHAVIOUR
//  Reset: pc_q=RESET_PC, outstanding=0, discard=0, FIFO empty; imem_req=0, if_valid=0,
//   if_pc/if_pc4/if_inst=0. Reset mid-transaction drops all in-flight state.
//  Issue: imem_req = !redirect_valid && (outstanding + fifo_count - pop) < FIFO_DEPTH,
//   pop = if_valid && if_ready. On req&&gnt: pc_q += 4 (mod 2^32, wraps 0xFFFF_FFFC->0), outstanding++.
//   imem_addr held stable while req && !gnt.
//  Response: imem_rvalid with discard>0 -> dropped, discard--; else pushed {pc,inst} to FIFO.
//   PC for each response is taken from an internal in-order PC tag queue (same depth).
//   rvalid with outstanding==0 is ignored (tolerated protocol violation, no state change).
//  Output: FIFO head registered; if_valid rises the cycle after the pushing rvalid.
//   Best case fetch-to-ID latency 2 cycles with 1-cycle memory; sustained 1 instr/cycle.
//   if_pc/if_inst held stable while if_valid && !if_ready.
//  Redirect (one cycle, highest priority): FIFO and tag queue flushed; if_valid forced 0
//   that cycle (any ID handshake ignored); imem_req forced 0; pc_q <= {redirect_pc[31:2],2'b00};
//   discard <= discard + outstanding(after this cycle's grant/rvalid) - (rvalid dropped or not
//   already counted); outstanding tracks only live requests. First new request next cycle.
//  Simultaneous: grant+redirect impossible (req gated). rvalid+redirect -> response dropped.
//   push+pop same cycle on full FIFO allowed (credit rule prevents overflow).
// STRUCTURE
//  Shared package/header cpu_defs: XLEN=32, RESET_PC default, NOP=32'h0000_0013, INST_W.
//  One sub-module: fetch_fifo (sync FIFO, DEPTH param, flush, push/pop, count) used
//   for the instruction buffer; PC tag queue is a second fetch_fifo instance.
//  Top holds pc_q, outstanding/discard counters, issue and redirect control.
// TESTING
//  Reset release, gnt=1, 1-cycle mem -> addrs 0,4,8..; if_valid at cycle 2, then 1/cycle.
//  if_ready=0 for 6 cycles -> exactly FIFO_DEPTH accepted fetches, imem_req drops, no loss.
//  2 outstanding, redirect_pc=0x100 -> both stale responses dropped, next if_pc=0x100.
//  redirect_pc=0x203 -> imem_addr=0x200, if_pc4=0x204.
//  gnt stalled 3 cycles at addr 0x40 -> addr stable, then 0x44; pc_q 0xFFFF_FFFC wraps to 0.
//  rst_n low mid-burst -> outputs zero immediately; late rvalid ignored; restart at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared CPU widths and constants for the fetch stage
package pc_fetch_unit_pkg;
  localparam int                 XLEN             = 32;
  localparam int                 INST_W           = 32;
  localparam logic [XLEN-1:0]    RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [INST_W-1:0]  NOP              = 32'h0000_0013;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction memory bus and IF/ID handoff signals
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic              imem_req;
  logic [XLEN-1:0]   imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [XLEN-1:0]   if_pc;
  logic [XLEN-1:0]   if_pc4;
  logic [INST_W-1:0] if_inst;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_pc4, if_inst,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_pc4, if_inst,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready
  );
endinterface

// File: rtl/pc_fetch_unit_fetch_fifo.sv
// rtl/pc_fetch_unit_fetch_fifo.sv - synchronous FIFO with flush, registered head and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Caller guarantees no push when full unless popping, and no pop when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - IF stage: owns the PC, issues word fetches, buffers instructions for ID
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  pc_fetch_unit_if.master   bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int DW = 8;

  logic [XLEN-1:0]        r_pc_q;
  logic [DW-1:0]          r_discard;
  logic [CW-1:0]          w_outstanding;
  logic [CW-1:0]          w_ibuf_count;
  logic [CW:0]            w_credit_used;
  logic [XLEN-1:0]        w_tag_pc;
  logic [XLEN+INST_W-1:0] w_ibuf_head;
  logic                   w_ibuf_empty;
  logic                   w_grant;
  logic                   w_pop;
  logic                   w_rv_drop;
  logic                   w_rv_live;
  logic                   w_push;

  assign w_ibuf_empty  = (w_ibuf_count == '0);
  assign bus.if_valid  = !redirect_valid && !w_ibuf_empty;
  assign w_pop         = bus.if_valid && bus.if_ready;

  // Credits cover both live fetches in flight and buffered entries, so the buffer never overflows.
  assign w_credit_used = (CW+1)'(w_outstanding) + (CW+1)'(w_ibuf_count) - (CW+1)'(w_pop);
  assign bus.imem_req  = rst_n && !redirect_valid && (w_credit_used < (CW+1)'(FIFO_DEPTH));
  assign bus.imem_addr = r_pc_q;
  assign w_grant       = bus.imem_req && bus.imem_gnt;

  // Stale responses (issued before a redirect) come back first and are swallowed by r_discard.
  assign w_rv_drop = bus.imem_rvalid && (r_discard != '0);
  assign w_rv_live = bus.imem_rvalid && (r_discard == '0) && (w_outstanding != '0);
  assign w_push    = w_rv_live && !redirect_valid;

  assign bus.if_pc   = w_ibuf_empty ? '0 : w_ibuf_head[XLEN+INST_W-1:INST_W];
  assign bus.if_inst = w_ibuf_empty ? '0 : w_ibuf_head[INST_W-1:0];
  assign bus.if_pc4  = w_ibuf_empty ? '0 : bus.if_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_q    <= RESET_PC;
      r_discard <= '0;
    end else if (redirect_valid) begin
      r_pc_q    <= word_align(redirect_pc);
      r_discard <= r_discard - DW'(w_rv_drop) + DW'(w_outstanding) - DW'(w_rv_live);
    end else begin
      if (w_grant) r_pc_q <= r_pc_q + XLEN'(4);
      r_discard <= r_discard - DW'(w_rv_drop);
    end
  end

  // The tag queue occupancy is the live outstanding-request count.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(XLEN)) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_grant),
    .i_data  (r_pc_q),
    .i_pop   (w_rv_live),
    .o_head  (w_tag_pc),
    .o_count (w_outstanding)
  );

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(XLEN+INST_W)) u_ibuf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  ({w_tag_pc, bus.imem_rdata}),
    .i_pop   (w_pop),
    .o_head  (w_ibuf_head),
    .o_count (w_ibuf_count)
  );
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized self-checking bench for pc_fetch_unit against a sequence-level model
module tb_pc_fetch_unit;
  import pc_fetch_unit_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  pc_fetch_unit_if bus();

  pc_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  logic [31:0] ga[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int epoch = 0;
  int gnt_pct, rv_pct, rdy_pct, lat_min, lat_max;
  int n_grant, n_pop, first_k;
  logic        d_rstn, d_redirect, late_rv;
  logic [31:0] d_target, first_pc, first_pc4;
  logic        s_rv_live, s_req, s_grant, s_valid, s_pop;
  logic [31:0] s_addr, s_pc, s_pc4;

  logic [31:0] m_fetch, m_pop;
  int          m_avail, m_live;
  logic        m_exp_req, m_exp_valid, m_pop_now;

  function automatic logic [31:0] f_inst(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    mreq_t e;
    @(negedge clk);
    rst_n           = d_rstn;
    redirect_valid  = d_redirect;
    redirect_pc     = d_target;
    bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
    bus.if_ready    = ($urandom_range(99) < rdy_pct);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    s_rv_live       = 1'b0;
    if (late_rv) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      late_rv         = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) < rv_pct) begin
      e = mq.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = f_inst(e.addr);
      s_rv_live       = (e.epoch == epoch) && !d_redirect && d_rstn;
    end
    if (d_redirect || !d_rstn) epoch++;
    #1;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_grant = s_req && bus.imem_gnt;
    s_valid = bus.if_valid;
    s_pop   = s_valid && bus.if_ready;
    s_pc    = bus.if_pc;
    s_pc4   = bus.if_pc4;
    if (s_grant) begin
      e.addr  = s_addr;
      e.epoch = epoch;
      e.due   = cyc + $urandom_range(lat_max, lat_min);
      mq.push_back(e);
      ga.push_back(s_addr);
      n_grant++;
    end
    if (s_pop) n_pop++;
    cyc++;
  endtask

  task automatic run_capture(input int n);
    first_k   = -1;
    first_pc  = 32'hBAD0_0000;
    first_pc4 = 32'hBAD0_0000;
    for (int k = 0; k < n; k++) begin
      step();
      if (s_valid && first_k < 0) begin
        first_k   = k;
        first_pc  = s_pc;
        first_pc4 = s_pc4;
      end
    end
  endtask

  task automatic redirect_to(input logic [31:0] t);
    d_redirect = 1'b1;
    d_target   = t;
    step();
    d_redirect = 1'b0;
  endtask

  // Model: PCs delivered to ID form consecutive words restarting at each redirect target.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      m_fetch = RST_PC;
      m_pop   = RST_PC;
      m_avail = 0;
      m_live  = 0;
    end else begin
      m_exp_valid = !redirect_valid && (m_avail > 0);
      m_pop_now   = m_exp_valid && bus.if_ready;
      m_exp_req   = !redirect_valid && ((m_live - (m_pop_now ? 1 : 0)) < DEPTH);
      chk("if_valid", 32'(bus.if_valid), 32'(m_exp_valid));
      chk("imem_req", 32'(bus.imem_req), 32'(m_exp_req));
      if (m_exp_req) chk("imem_addr", bus.imem_addr, m_fetch);
      if (m_exp_valid) begin
        chk("if_pc", bus.if_pc, m_pop);
        chk("if_inst", bus.if_inst, f_inst(m_pop));
        chk("if_pc4", bus.if_pc4, m_pop + 32'd4);
      end
      if (redirect_valid) begin
        m_fetch = redirect_pc & ~32'h3;
        m_pop   = m_fetch;
        m_avail = 0;
        m_live  = 0;
      end else begin
        if (m_exp_req && bus.imem_gnt) begin
          m_fetch = m_fetch + 32'd4;
          m_live++;
        end
        if (m_pop_now) begin
          m_pop = m_pop + 32'd4;
          m_live--;
          m_avail--;
        end
        if (s_rv_live) m_avail++;
      end
    end
  end

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.if_ready = 1'b0;
    d_rstn = 1'b0; d_redirect = 1'b0; d_target = '0; late_rv = 1'b0;
    gnt_pct = 100; rv_pct = 100; rdy_pct = 100; lat_min = 1; lat_max = 1;
    n_grant = 0; n_pop = 0;
    repeat (3) step();
    chk("reset_req", 32'(bus.imem_req), 32'd0);
    chk("reset_valid", 32'(bus.if_valid), 32'd0);
    chk("reset_pc", bus.if_pc, 32'd0);
    chk("reset_pc4", bus.if_pc4, 32'd0);
    chk("reset_inst", bus.if_inst, 32'd0);

    // Streaming from reset with a 1-cycle memory
    d_rstn = 1'b1; n_grant = 0; n_pop = 0; ga.delete();
    run_capture(8);
    chk("first_valid_cycle", 32'(first_k), 32'd2);
    chk("first_pc", first_pc, 32'h0);
    chk("fetch_addr0", ga[0], 32'h0);
    chk("fetch_addr1", ga[1], 32'h4);
    chk("fetch_addr2", ga[2], 32'h8);

    // ID stall: credits run out at exactly DEPTH live fetches
    rdy_pct = 0;
    repeat (6) step();
    chk("stall_req", 32'(s_req), 32'd0);
    chk("stall_valid", 32'(s_valid), 32'd1);
    chk("stall_live", 32'(n_grant - n_pop), 32'(DEPTH));
    rdy_pct = 100;
    repeat (10) step();

    // Two stale fetches in flight at redirect
    gnt_pct = 0;
    repeat (8) step();
    gnt_pct = 100; lat_min = 5; lat_max = 5;
    repeat (2) step();
    chk("two_outstanding", 32'(mq.size()), 32'd2);
    d_redirect = 1'b1; d_target = 32'h100;
    step();
    d_redirect = 1'b0;
    chk("redir_req", 32'(s_req), 32'd0);
    chk("redir_valid", 32'(s_valid), 32'd0);
    lat_min = 1; lat_max = 1;
    run_capture(14);
    chk("redir_first_pc", first_pc, 32'h100);

    // Misaligned target
    redirect_to(32'h203);
    step();
    chk("align_addr", s_addr, 32'h200);
    chk("align_req", 32'(s_req), 32'd1);
    run_capture(10);
    chk("align_pc4", first_pc4, 32'h204);

    // Grant stall holds the address
    gnt_pct = 0;
    redirect_to(32'h40);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gnt_stall_addr", s_addr, 32'h40);
      chk("gnt_stall_req", 32'(s_req), 32'd1);
    end
    gnt_pct = 100;
    step();
    chk("gnt_release_grant", 32'(s_grant), 32'd1);
    step();
    chk("gnt_next_addr", s_addr, 32'h44);
    repeat (6) step();

    // PC wrap at top of address space
    redirect_to(32'hFFFF_FFF8);
    ga.delete();
    repeat (4) step();
    chk("wrap_addr1", ga[1], 32'hFFFF_FFFC);
    chk("wrap_addr2", ga[2], 32'h0);
    repeat (10) step();

    // Reset mid-burst, then a late response after release
    lat_min = 3; lat_max = 3;
    repeat (3) step();
    d_rstn = 1'b0;
    step();
    chk("midrst_req", 32'(s_req), 32'd0);
    chk("midrst_valid", 32'(s_valid), 32'd0);
    chk("midrst_pc", s_pc, 32'd0);
    chk("midrst_pc4", s_pc4, 32'd0);
    mq.delete();
    step();
    d_rstn = 1'b1; late_rv = 1'b1; lat_min = 1; lat_max = 1; ga.delete();
    run_capture(8);
    chk("restart_addr", ga[0], RST_PC);
    chk("restart_pc", first_pc, RST_PC);

    // Randomized traffic
    gnt_pct = 75; rv_pct = 80; rdy_pct = 70; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      d_redirect = ($urandom_range(99) < 3);
      d_target   = ($urandom_range(9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      step();
    end
    d_redirect = 1'b0;
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
